adder_residue_checker: RTL
==========================

ADDER_RESIDUE_CHECKER -- requirements
Module: adder_residue_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/sum width.
REQ-002 SHALL have parameter ERR_THRESH, default 3, errors since clear that force FAULT (range 1..255).
REQ-003 SHALL have parameter CNT_W, default 16, error-counter width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 op_valid  in  1  a/b/cin valid this cycle (same cycle the adder samples them).
REQ-007 a, b  in  WIDTH  operands as presented to the adder.
REQ-008 cin  in  1  carry-in as presented to the adder.
REQ-009 s  in  WIDTH  registered sum from the adder.
REQ-010 cout  in  1  registered carry-out from the adder.
REQ-011 clr  in  1  clears error counter and FAULT state.
REQ-012 err  out  1  one-cycle pulse: residue mismatch detected.
REQ-013 err_cnt  out  CNT_W  saturating total mismatch count.
REQ-014 fault  out  1  high while FSM is in FAULT.

Function
REQ-015 Stage 1 SHALL, when op_valid=1, register Ra=(a+b+cin) mod 3 and a valid flag; the valid flag SHALL be 0 after a cycle with op_valid=0.
REQ-016 Stage 2 SHALL compute Rs=(cout*(2^WIDTH mod 3)+s) mod 3 from current s/cout and compare with registered Ra when the stage-1 valid flag is set.
REQ-017 Residues SHALL be computed without a WIDTH-bit divider: 2-bit digit folding reduction, combinational, any WIDTH multiple of 2.
REQ-018 err SHALL assert exactly in cycle t+2 for operands with op_valid in cycle t; back-to-back operands SHALL each be checked (throughput 1/cycle).
REQ-019 err_cnt SHALL increment by 1 per err pulse and saturate at 2^CNT_W-1.
REQ-020 FSM states: OK (0 errors since clear), DEGRADED (1..ERR_THRESH-1), FAULT (>=ERR_THRESH); FAULT SHALL be sticky until clr or reset.
REQ-021 OK->DEGRADED on first err; DEGRADED->FAULT on the err reaching ERR_THRESH; ERR_THRESH=1 SHALL go OK->FAULT directly.
REQ-022 clr SHALL return FSM to OK and err_cnt to 0 on next edge; a mismatch evaluated in the clr cycle SHALL be discarded (clr wins), pipeline contents SHALL NOT be flushed by clr.
REQ-023 fault SHALL be registered, asserting in the same cycle as the err pulse that reaches ERR_THRESH.

Reset
REQ-024 rst_n=0 at a rising edge SHALL set err=0, err_cnt=0, fault=0, FSM=OK, all pipeline valid flags=0.
REQ-025 Operands in flight at reset SHALL be dropped; no err for them after reset release.
REQ-026 First checkable operand after release SHALL be one with op_valid in the first cycle rst_n=1.

Configuration
REQ-027 Macro ADDER_CHK_MOD7_EN defined: a parallel mod-7 residue check (2^64 mod 7 = 2) SHALL be added; err = mod-3 mismatch OR mod-7 mismatch, same latency.
REQ-028 Macro undefined: mod-3 check only; no mod-7 logic SHALL be synthesised; ports identical in both builds.

Structure
REQ-029 Package adder_chk_pkg SHALL hold the FSM state typedef (OK, DEGRADED, FAULT) and constants for 2^WIDTH mod 3 and mod 7.
REQ-030 Residue reduction SHALL be one sub-module, residue_mod, parameterised by width and modulus (3 or 7), instantiated per operand sum and per result.

Verification
REQ-031 a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, s=0, cout=1 (correct) -> err=0 at t+2, err_cnt=0.
REQ-032 Same operands, s=1 (fault injected) -> err=1 at t+2 only, err_cnt=1, FSM=DEGRADED, fault=0.
REQ-033 Three faulty ops back-to-back, ERR_THRESH=3 -> err high t+2..t+4, fault=1 from t+4, stays 1 over 20 clean ops; clr -> fault=0, err_cnt=0 next cycle.
REQ-034 a=5, b=7, cin=1, s=16 (off by 3) -> no err without ADDER_CHK_MOD7_EN; err=1 at t+2 with it.
REQ-035 Faulty op in cycle t, rst_n=0 in t+1 -> no err at t+2, all outputs at reset values.
REQ-036 clr asserted in same cycle a mismatch is evaluated -> err=0, err_cnt=0, FSM=OK.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg
//   Shared definitions for the adder residue checker:
//   - state_e    : health FSM states (OK, DEGRADED, FAULT)
//   - P2W64_MOD3 : 2^64 mod 3
//   - P2W64_MOD7 : 2^64 mod 7
//   - pow2_mod   : 2^w mod m for widths other than 64 (elaboration only)
//   - mod_small  : modulo of a small residue sum (at most 5 bits)
package adder_chk_pkg;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        DEGRADED = 2'd1,
        FAULT    = 2'd2
    } state_e;

    localparam int unsigned P2W64_MOD3 = 1;
    localparam int unsigned P2W64_MOD7 = 2;

    function automatic int unsigned pow2_mod(input int unsigned w, input int unsigned m);
        int unsigned r;
        r = 1 % m;
        for (int unsigned i = 0; i < w; i++) r = (r * 2) % m;
        return r;
    endfunction

    function automatic logic [2:0] mod_small(input logic [4:0] v, input logic [2:0] m);
        return 3'(v % 5'(m));
    endfunction

endpackage

// File: rtl/residue_mod.sv
// residue_mod
//   Combinational residue x mod M (M = 3 or 7) using 2-bit digit folding:
//   each 2-bit digit is weighted by 4^k mod M and the weighted digits are
//   summed, leaving only a small final modulo.
//   Ports:
//     x_i [W-1:0] : value to reduce (W a multiple of 2)
//     r_o [2:0]   : residue
module residue_mod #(
    parameter int unsigned W = 64,
    parameter int unsigned M = 3
) (
    input  logic [W-1:0] x_i,
    output logic [2:0]   r_o
);

    // Each digit contributes at most 3 * (M-1) <= 18.
    localparam int unsigned SW = $clog2((W / 2) * 18 + 1);

    logic [SW-1:0] acc;

    always_comb begin
        int unsigned wt;
        acc = '0;
        wt  = 1;
        for (int unsigned k = 0; k < W / 2; k++) begin
            acc = acc + SW'(x_i[2*k +: 2]) * SW'(wt);
            wt  = (wt * 4) % M;
        end
    end

    assign r_o = 3'(acc % SW'(M));

endmodule

// File: rtl/adder_residue_checker.sv
// adder_residue_checker
//   Concurrent residue check of a registered adder. Stage 1 registers the
//   residue of a+b+cin; one cycle later the residue of {cout,s} is compared
//   against it and a mismatch is reported as a one-cycle err pulse two
//   cycles after the operands. A saturating counter and a health FSM
//   (OK / DEGRADED / FAULT) track mismatches since the last clr.
//   Optional: define ADDER_CHK_MOD7_EN to add a parallel mod-7 check.
//   Ports:
//     clk, rst_n      : clock, synchronous active-low reset
//     op_valid, a, b, cin : operands as presented to the adder
//     s, cout         : registered adder result (one cycle after operands)
//     clr             : clear counter and FSM (wins over a same-cycle mismatch)
//     err             : one-cycle mismatch pulse
//     err_cnt         : saturating mismatch count
//     fault           : high while the FSM is in FAULT
module adder_residue_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ERR_THRESH = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    input  logic             clr,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [2:0] C3 = 3'((WIDTH == 64) ? P2W64_MOD3 : pow2_mod(WIDTH, 3));

    logic [2:0] ra3, rb3, rs3, sum3_d, res3;
    logic       v1_q;
    logic [2:0] ra3_q;
    logic       mismatch;

    residue_mod #(.W(WIDTH), .M(3)) u_a3 (.x_i(a), .r_o(ra3));
    residue_mod #(.W(WIDTH), .M(3)) u_b3 (.x_i(b), .r_o(rb3));
    residue_mod #(.W(WIDTH), .M(3)) u_s3 (.x_i(s), .r_o(rs3));

    assign sum3_d = mod_small(5'(ra3) + 5'(rb3) + 5'(cin), 3'd3);
    assign res3   = mod_small(5'(rs3) + (cout ? 5'(C3) : 5'd0), 3'd3);

`ifdef ADDER_CHK_MOD7_EN
    localparam logic [2:0] C7 = 3'((WIDTH == 64) ? P2W64_MOD7 : pow2_mod(WIDTH, 7));

    logic [2:0] ra7, rb7, rs7, sum7_d, res7;
    logic [2:0] ra7_q;

    residue_mod #(.W(WIDTH), .M(7)) u_a7 (.x_i(a), .r_o(ra7));
    residue_mod #(.W(WIDTH), .M(7)) u_b7 (.x_i(b), .r_o(rb7));
    residue_mod #(.W(WIDTH), .M(7)) u_s7 (.x_i(s), .r_o(rs7));

    assign sum7_d = mod_small(5'(ra7) + 5'(rb7) + 5'(cin), 3'd7);
    assign res7   = mod_small(5'(rs7) + (cout ? 5'(C7) : 5'd0), 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n)        ra7_q <= '0;
        else if (op_valid) ra7_q <= sum7_d;
    end

    assign mismatch = v1_q & ((res3 != ra3_q) | (res7 != ra7_q));
`else
    assign mismatch = v1_q & (res3 != ra3_q);
`endif

    // Stage 1: operand residue and valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            ra3_q <= '0;
        end else begin
            v1_q <= op_valid;
            if (op_valid) ra3_q <= sum3_d;
        end
    end

    // Stage 2: error pulse, counter and health FSM all update on the edge
    // after the comparison so err and fault rise together.
    state_e           state_q, state_d;
    logic [7:0]       thr_q, thr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             fault_q;

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (clr) begin
            state_d = OK;
            thr_d   = '0;
            cnt_d   = '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                OK, DEGRADED: begin
                    thr_d   = thr_q + 8'd1;
                    state_d = (thr_d >= 8'(ERR_THRESH)) ? FAULT : DEGRADED;
                end
                default: state_d = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OK;
            thr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fault_q <= (state_d == FAULT);
        end
    end

    assign err     = err_q;
    assign err_cnt = cnt_q;
    assign fault   = fault_q;

endmodule
